add_multicycle: RTL and testbench
=================================

ADD_MULTICYCLE -- requirements
Module: add_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SLICE, default 8, bits summed per clock; WIDTH SHALL be an integer multiple of SLICE, with WIDTH/SLICE >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 sub  input  1  1 = compute A - B, 0 = compute A + B; sampled with start.
REQ-007 carry_in  input  1  carry injected into bit 0; sampled with start.
REQ-008 a  input  WIDTH  operand A; sampled with start.
REQ-009 b  input  WIDTH  operand B; sampled with start.
REQ-010 busy  output  1  high while an operation is in progress (RUN state).
REQ-011 done  output  1  single-cycle pulse when the result registers update.
REQ-012 out  output  WIDTH  result, registered and held until the next done.
REQ-013 carry_out  output  1  carry out of bit WIDTH-1, held with out.
REQ-014 overflow  output  1  two's-complement overflow, held with out.
REQ-015 zero  output  1  high when out == 0, held with out.
REQ-016 negative  output  1  equals out[WIDTH-1], held with out.

Function
REQ-017 States: IDLE, RUN, DONE; encoding taken from the shared package.
REQ-018 IDLE with start=1 at an edge SHALL latch a, b XOR {WIDTH{sub}}, sub, and carry_in, clear the slice index, and go to RUN.
REQ-019 The initial carry SHALL be carry_in OR sub (the two's-complement increment; sub=1 with carry_in=1 adds exactly one).
REQ-020 RUN: each edge adds slice index i (bits i*SLICE .. i*SLICE+SLICE-1) with the running carry, stores the partial sum, stores the carry, and increments i.
REQ-021 After slice N-1 (N = WIDTH/SLICE) is processed, the FSM goes to DONE; that same edge loads out, carry_out, overflow, zero, and negative.
REQ-022 overflow SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 DONE lasts exactly one cycle with done=1, then goes to IDLE. A start during DONE is ignored.
REQ-024 Latency: start sampled at edge k gives done=1 in the cycle after edge k+N; busy=1 in the cycles after edges k .. k+N-1.
REQ-025 start while busy or done is high SHALL be ignored and SHALL NOT alter latched operands.
REQ-026 Input changes after the start edge SHALL NOT affect the result in progress.
REQ-027 Result outputs SHALL change only at the edge that raises done; they hold their values in IDLE indefinitely.
REQ-028 Back-to-back: start asserted in the first IDLE cycle after DONE SHALL be accepted, giving one issue per N+2 cycles.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and set busy=0, done=0, out=0, carry_out=0, overflow=0, zero=1, negative=0, and the slice index and carry registers to 0.
REQ-030 rst asserted mid-RUN SHALL abandon the operation with no done pulse; the first start after release begins a fresh operation.

Structure
REQ-031 A shared package SHALL hold the state enum and the default WIDTH and SLICE constants.
REQ-032 One sub-module, add_slice (parametrised SLICE), SHALL compute the combinational sum, carry out, and carry into the slice MSB. A single instance SHALL be reused every cycle.
REQ-033 The datapath SHALL contain no WIDTH-wide combinational adder; the carry chain is at most SLICE bits per cycle.

Verification (WIDTH=32, SLICE=8, N=4)
REQ-034 a=0x0000_0005, b=0x0000_0003, sub=0, cin=0 -> done in the 5th cycle after start; out=0x0000_0008, carry_out=0, overflow=0, zero=0.
REQ-035 a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> out=0x8000_0000, overflow=1, negative=1, carry_out=0.
REQ-036 a=0x0000_0005, b=0x0000_0005, sub=1 -> out=0, zero=1, carry_out=1, overflow=0; a=0x8000_0000, b=1, sub=1 -> out=0x7FFF_FFFF, overflow=1.
REQ-037 a=0xFFFF_FFFF, b=0, cin=1 -> out=0, carry_out=1 (carry crosses all slice boundaries); a, b, and start toggled during RUN -> result unchanged and a single done pulse.
REQ-038 rst pulsed in the 2nd RUN cycle -> no done and all outputs at their reset values; a new start of 1+1 then yields out=2 after the full latency.
REQ-039 Two operations back-to-back with start held high -> exactly two done pulses spaced N+2 cycles apart, each with the correct result.

Source files
------------

// File: rtl/add_multicycle_pkg.sv
// Shared definitions for the slice-serial adder: FSM states and default geometry.
package add_multicycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

endpackage

// File: rtl/add_multicycle_add_slice.sv
// One SLICE-bit adder stage; reused every RUN cycle by add_multicycle.
module add_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [SLICE:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
    assign o_sum  = w_full[SLICE-1:0];
    assign o_cout = w_full[SLICE];
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign o_cmsb = i_a[SLICE-1] ^ i_b[SLICE-1] ^ w_full[SLICE-1];

endmodule

// File: rtl/add_multicycle.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed SLICE bits per clock
// through a single shared add_slice, with registered flags held until next done.
module add_multicycle
    import add_multicycle_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output state_t           o_dbg_state
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = $clog2(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    // Handshake: start is a request accepted only on an edge where the FSM is
    // in IDLE (busy=0, done=0); it is ignored otherwise and nothing is latched.

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [SLICE-1:0] r_sum_sl [N];
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic [SLICE-1:0] w_a_sl [N];
    logic [SLICE-1:0] w_b_sl [N];
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_result;

    for (genvar j = 0; j < N; j++) begin : g_slices
        assign w_a_sl[j] = r_a[j*SLICE +: SLICE];
        assign w_b_sl[j] = r_b[j*SLICE +: SLICE];
        // The top slice is still in flight on the final edge, so take it live.
        if (j == N - 1) begin : g_top
            assign w_result[j*SLICE +: SLICE] = w_sum;
        end else begin : g_low
            assign w_result[j*SLICE +: SLICE] = r_sum_sl[j];
        end
    end

    add_slice #(
        .SLICE (SLICE)
    ) u_add_slice (
        .i_a    (w_a_sl[r_idx]),
        .i_b    (w_b_sl[r_idx]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            for (int j = 0; j < N; j++) begin
                r_sum_sl[j] <= '0;
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= carry_in | sub;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum_sl[r_idx] <= w_sum;
                    r_carry         <= w_cout;
                    r_idx           <= r_idx + IDXW'(1);
                    if (r_idx == LAST_IDX) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= w_result;
                        r_cout  <= w_cout;
                        r_ovf   <= w_cmsb ^ w_cout;
                        r_zero  <= ~|w_result;
                        r_neg   <= w_result[WIDTH-1];
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign out         = r_out;
    assign carry_out   = r_cout;
    assign overflow    = r_ovf;
    assign zero        = r_zero;
    assign negative    = r_neg;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_add_multicycle.sv
// Randomized scoreboard bench for add_multicycle (WIDTH=32, SLICE=8).
`timescale 1ns/1ps
module tb_add_multicycle;
  import add_multicycle_pkg::*;

  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         carry_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         negative;
  state_t       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  add_multicycle #(.WIDTH(W), .SLICE(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sub         (sub),
    .carry_in    (carry_in),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero),
    .negative    (negative),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    int           issue_c;
    int           done_c;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  logic [W-1:0] h_out;
  logic         h_cout;
  logic         h_ovf;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub, input logic mcin, input int issue_c);
    exp_t e;
    logic [W-1:0] opb;
    logic [W:0]   full;
    opb = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, opb} + (W+1)'(mcin | msub);
    e.res = full[W-1:0];
    e.cout = full[W];
    e.ovf = (ma[W-1] == opb[W-1]) && (full[W-1] != ma[W-1]);
    e.issue_c = issue_c;
    e.done_c = issue_c + N;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_held_reset();
    h_out = '0;
    h_cout = 1'b0;
    h_ovf = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", out, '0);
    chk("rst_cout", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_neg", 32'(negative), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- monitor ----------------
  logic m_exp_busy;
  exp_t m_e;

  always @(negedge clk) begin
    if (!rst) begin
      m_exp_busy = (exp_q.size() > 0) && (cyc >= exp_q[0].issue_c) && (cyc < exp_q[0].done_c);
      chk("busy", 32'(busy), 32'(m_exp_busy));
      if (m_exp_busy) chk("state_run", 32'(dbg_state), 32'(ST_RUN));
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_done: got done=1, expected no pending op (cycle %0d)", cyc);
        end else begin
          m_e = exp_q.pop_front();
          chk("latency", 32'(cyc), 32'(m_e.done_c));
          chk("out", out, m_e.res);
          chk("carry_out", 32'(carry_out), 32'(m_e.cout));
          chk("overflow", 32'(overflow), 32'(m_e.ovf));
          chk("zero", 32'(zero), 32'(m_e.res == '0));
          chk("negative", 32'(negative), 32'(m_e.res[W-1]));
          h_out = m_e.res;
          h_cout = m_e.cout;
          h_ovf = m_e.ovf;
        end
      end else begin
        if (exp_q.size() > 0 && cyc >= exp_q[0].done_c) begin
          m_e = exp_q.pop_front();
          n_vec++;
          n_fail++;
          $display("FAIL missing_done: got done=0, expected done at cycle %0d", m_e.done_c);
        end
        chk("hold_out", out, h_out);
        chk("hold_cout", 32'(carry_out), 32'(h_cout));
        chk("hold_ovf", 32'(overflow), 32'(h_ovf));
        chk("hold_zero", 32'(zero), 32'(h_out == '0));
        chk("hold_neg", 32'(negative), 32'(h_out[W-1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || done || exp_q.size() > 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b, expected idle", busy, done);
      exp_q.delete();
    end
  endtask

  // Called at a negedge with the DUT idle; the next edge accepts the op.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic icin);
    a = ia;
    b = ib;
    sub = isub;
    carry_in = icin;
    start = 1'b1;
    exp_q.push_back(model(ia, ib, isub, icin, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom_range(0, 1));
    carry_in = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] dir_a [7] = '{32'h0000_0005, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_00FF};
  logic [W-1:0] dir_b [7] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0005, 32'h0000_0001,
                              32'h0000_0000, 32'h0000_0003, 32'h0000_0001};
  logic         dir_s [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         dir_c [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int k;
    set_held_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      issue(dir_a[i], dir_b[i], dir_s[i], dir_c[i]);
    end

    // Inputs and start toggled throughout RUN must not disturb the result.
    wait_idle();
    a = 32'h1234_5678;
    b = 32'h0FED_CBA9;
    sub = 1'b0;
    carry_in = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, cyc + 1));
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      sub = 1'($urandom_range(0, 1));
      carry_in = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b0;

    // Reset in the second RUN cycle abandons the operation.
    wait_idle();
    issue(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    set_held_reset();
    #1 check_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_out", out, '0);
    chk("post_rst_zero", 32'(zero), 32'd1);
    wait_idle();
    issue(32'd1, 32'd1, 1'b0, 1'b0);

    // Back-to-back with start held high: second op accepted N+2 edges later.
    wait_idle();
    a = 32'h0000_1000;
    b = 32'h0000_0234;
    sub = 1'b0;
    carry_in = 1'b0;
    start = 1'b1;
    k = cyc + 1;
    exp_q.push_back(model(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, k));
    exp_q.push_back(model(32'h0000_0050, 32'h0000_0070, 1'b1, 1'b0, k + N + 2));
    @(negedge clk);
    a = 32'h0000_0050;
    b = 32'h0000_0070;
    sub = 1'b1;
    repeat (N + 2) @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
